// File: rtl/conv_frame_loader.sv
// conv_frame_loader: collects one raster-order frame of pixels into a register buffer,
// presents it to conv_layer with conv_enable held until conv_done, then waits for
// conv_done to fall before reopening for the next frame.
module conv_frame_loader #(
  parameter int DATA_X    = 28,
  parameter int DATA_Y    = 28,
  parameter int DATA_SIZE = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_SIZE-1:0]                pix_data,
  input  logic                                pix_valid,
  input  logic                                pix_last,
  output logic                                pix_ready,
  output logic [DATA_X*DATA_Y*DATA_SIZE-1:0]  data_flat,
  output logic                                conv_enable,
  input  logic                                conv_done,
  output logic                                frame_err,
  output logic                                busy
);

  localparam int RW   = (DATA_X > 1) ? $clog2(DATA_X) : 1;
  localparam int CW   = (DATA_Y > 1) ? $clog2(DATA_Y) : 1;
  localparam int FW   = DATA_X * DATA_Y * DATA_SIZE;
  localparam int OW   = (FW > 1) ? $clog2(FW) : 1;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [FW-1:0]   data_flat_q, data_flat_d;
  logic            pix_ready_q, pix_ready_d;
  logic            conv_enable_q, conv_enable_d;
  logic            busy_q, busy_d;
  logic            frame_err_q, frame_err_d;

  logic            accept_s;
  logic            last_pos_s;
  logic            col_wrap_s;
  logic [OW-1:0]   off_s;

  // Handshake qualifier, final-position detect and bit offset of the current pixel slot.
  always_comb begin
    accept_s   = pix_valid & pix_ready_q;
    col_wrap_s = (col_q == CW'(DATA_Y - 1));
    last_pos_s = (row_q == RW'(DATA_X - 1)) && col_wrap_s;
    off_s      = (OW'(row_q) * OW'(DATA_Y) + OW'(col_q)) * OW'(DATA_SIZE);
  end

  // Next-state, counter, buffer and output computation.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    data_flat_d = data_flat_q;
    frame_err_d = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (accept_s) begin
          data_flat_d[off_s +: DATA_SIZE] = pix_data;
          if (last_pos_s) begin
            // Count-based framing: a full frame always runs, missing pix_last is only flagged.
            row_d       = '0;
            col_d       = '0;
            state_d     = S_RUN;
            frame_err_d = ~pix_last;
          end else if (pix_last) begin
            // Early pix_last: drop the partial frame, old pixels get overwritten later.
            row_d       = '0;
            col_d       = '0;
            frame_err_d = 1'b1;
          end else if (col_wrap_s) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        if (conv_done) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // A conv_done still high from this frame must not release the next one.
        if (!conv_done) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_LOAD;
        row_d   = '0;
        col_d   = '0;
      end
    endcase
    pix_ready_d   = (state_d == S_LOAD);
    conv_enable_d = (state_d == S_RUN);
    busy_d        = (state_d != S_LOAD);
  end

  // State, counters, frame buffer and registered outputs; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_LOAD;
      row_q         <= '0;
      col_q         <= '0;
      data_flat_q   <= '0;
      pix_ready_q   <= 1'b1;
      conv_enable_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      data_flat_q   <= data_flat_d;
      pix_ready_q   <= pix_ready_d;
      conv_enable_q <= conv_enable_d;
      busy_q        <= busy_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign pix_ready   = pix_ready_q;
  assign conv_enable = conv_enable_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;
  assign data_flat   = data_flat_q;

endmodule

// File: tb/tb_conv_frame_loader.sv
// Self-checking bench for conv_frame_loader: randomized pixel streams and conv_done
// timing compared against a frame-level reference model (pixel index + frame array).
module tb_conv_frame_loader;

  localparam int DX   = 28;
  localparam int DY   = 28;
  localparam int DS   = 8;
  localparam int NPIX = DX * DY;

  localparam int P_LOAD  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;

  logic                 clk;
  logic                 rst;
  logic [DS-1:0]        pix_data;
  logic                 pix_valid;
  logic                 pix_last;
  logic                 pix_ready;
  logic [NPIX*DS-1:0]   data_flat;
  logic                 conv_enable;
  logic                 conv_done;
  logic                 frame_err;
  logic                 busy;

  conv_frame_loader #(.DATA_X(DX), .DATA_Y(DY), .DATA_SIZE(DS)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_last    (pix_last),
    .pix_ready   (pix_ready),
    .data_flat   (data_flat),
    .conv_enable (conv_enable),
    .conv_done   (conv_done),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame contents, next pixel index, phase, pending error pulse.
  logic [7:0] m_frame [0:NPIX-1];
  int         m_pos;
  int         m_phase;
  int         m_prev;
  logic       m_err;
  int         run_cnt, run_delay, drain_cnt, drain_hold;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic full_check();
    for (int i = 0; i < NPIX; i++) begin
      check_eq($sformatf("pix%0d", i), 32'(data_flat[i*DS +: DS]), 32'(m_frame[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NPIX; i++) m_frame[i] = 8'h00;
    m_pos   = 0;
    m_phase = P_LOAD;
    m_prev  = P_LOAD;
    m_err   = 1'b0;
  endtask

  // Called at a negedge: compare outputs, drive one cycle of inputs, advance the model.
  task automatic tick(input logic v, input logic l, input logic [7:0] d, output logic acc);
    logic dn;
    int   idx;
    check_eq("pix_ready",   32'(pix_ready),   32'(m_phase == P_LOAD));
    check_eq("conv_enable", 32'(conv_enable), 32'(m_phase == P_RUN));
    check_eq("busy",        32'(busy),        32'(m_phase != P_LOAD));
    check_eq("frame_err",   32'(frame_err),   32'(m_err));
    if (m_phase != m_prev) begin
      full_check();
    end else begin
      idx = $urandom_range(NPIX - 1, 0);
      check_eq("pix_rand", 32'(data_flat[idx*DS +: DS]), 32'(m_frame[idx]));
    end
    m_prev = m_phase;
    if (m_phase == P_RUN) begin
      dn = (run_cnt >= run_delay);
      run_cnt++;
    end else if (m_phase == P_DRAIN) begin
      dn = (drain_cnt < drain_hold);
      drain_cnt++;
    end else begin
      dn = 1'b0;
    end
    conv_done = dn;
    pix_valid = v;
    pix_last  = l;
    pix_data  = d;
    acc       = v && (m_phase == P_LOAD);
    m_err     = 1'b0;
    if (m_phase == P_LOAD) begin
      if (acc) begin
        m_frame[m_pos] = d;
        if (m_pos == NPIX - 1) begin
          m_pos     = 0;
          m_phase   = P_RUN;
          m_err     = !l;
          run_cnt   = 0;
          run_delay = $urandom_range(3, 0);
        end else if (l) begin
          m_pos = 0;
          m_err = 1'b1;
        end else begin
          m_pos++;
        end
      end
    end else if (m_phase == P_RUN) begin
      if (dn) begin
        m_phase    = P_DRAIN;
        drain_cnt  = 0;
        drain_hold = $urandom_range(3, 0);
      end
    end else begin
      if (!dn) m_phase = P_LOAD;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Stream n accepted pixels; last_at is the 1-based pixel that carries pix_last (0 = none).
  task automatic send_frame(input int n, input int last_at, input int gap_pct,
                            input int mode, input int wait_load);
    int         k = 0;
    int         guard = 0;
    logic       v, l, acc;
    logic [7:0] d;
    while (k < n && guard < 20000) begin
      v = ($urandom_range(99, 0) >= gap_pct);
      d = (mode == 0) ? 8'(k) : 8'($urandom);
      l = v ? (k + 1 == last_at) : 1'($urandom);
      tick(v, l, d, acc);
      if (acc) k++;
      guard++;
    end
    check_eq("stream_timeout", 32'(guard < 20000), 32'd1);
    if (wait_load != 0) begin
      guard = 0;
      while (m_phase != P_LOAD && guard < 100) begin
        tick(1'b1, 1'b0, 8'($urandom), acc);
        guard++;
      end
      check_eq("reload_timeout", 32'(m_phase == P_LOAD), 32'd1);
    end
  endtask

  // Assert reset mid-cycle and verify the outputs drop without waiting for a clock edge.
  task automatic apply_reset();
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    conv_done = 1'b0;
    #1;
    check_eq("rst_ready",  32'(pix_ready),   32'd1);
    check_eq("rst_enable", 32'(conv_enable), 32'd0);
    check_eq("rst_busy",   32'(busy),        32'd0);
    check_eq("rst_err",    32'(frame_err),   32'd0);
    model_reset();
    full_check();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic acc_s;

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    pix_data  = 8'h00;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    conv_done = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset();
    send_frame(NPIX, NPIX, 0, 0, 1);    // ramp pattern, continuous valid
    send_frame(NPIX, NPIX, 30, 0, 1);   // same pattern with idle gaps
    send_frame(NPIX, NPIX, 30, 1, 1);   // random pixels
    send_frame(100, 100, 0, 1, 1);      // early pix_last
    send_frame(NPIX, NPIX, 20, 1, 1);   // full frame after discard
    send_frame(NPIX, 0, 0, 1, 1);       // missing pix_last
    send_frame(400, 0, 10, 1, 1);       // partial frame, then reset
    apply_reset();
    send_frame(NPIX, NPIX, 0, 0, 0);    // stop in RUN
    tick(1'b1, 1'b0, 8'hA5, acc_s);
    apply_reset();
    send_frame(NPIX, NPIX, 25, 1, 1);   // recovery frame from (0,0)
    tick(1'b0, 1'b0, 8'h00, acc_s);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
